// File: rtl/one_unit_pkg.sv
// Shared definitions for the one-unit FastICA sequencer.
//   state_t       : sequencer state encoding (IDLE..DONE), ST_W bits
//   ITER_W_DEF    : default iteration counter width
//   MAX_ITER_DEF  : default iteration limit
//   lat_last()    : true on the final cycle of a stage held for 'lat' cycles
package one_unit_pkg;

  localparam int ST_W         = 3;
  localparam int ITER_W_DEF   = 8;
  localparam int MAX_ITER_DEF = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    UPD  = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6
  } state_t;

  // The latency counter starts at 0 on stage entry, so the last cycle of a
  // stage held for 'lat' cycles is cnt == lat-1.
  function automatic logic lat_last(input logic [31:0] cnt, input int lat);
    return (cnt == 32'(lat - 1));
  endfunction

endpackage

// File: rtl/one_unit_mul_seq_if.sv
// Control bundle between the FastICA iteration sequencer and its environment.
//   master : sequencer side (receives start/abort/convergence result,
//            drives stage enables, iteration count and run status)
//   slave  : controller/datapath side (the mirror image)
//   start, abort         : run control
//   conv_valid, conv_flag: convergence checker result
//   busy, done           : run status (done is a 1-cycle pulse)
//   en_load..en_upd      : stage enables, at most one high
//   iter_cnt             : completed iterations
//   converged, timeout   : sticky end-of-run reason
interface one_unit_mul_seq_if #(
  parameter int ITER_W = one_unit_pkg::ITER_W_DEF
);

  logic              start;
  logic              abort;
  logic              conv_valid;
  logic              conv_flag;
  logic              busy;
  logic              en_load;
  logic              en_mul1;
  logic              en_mul2;
  logic              en_upd;
  logic [ITER_W-1:0] iter_cnt;
  logic              done;
  logic              converged;
  logic              timeout;

  modport master (
    input  start, abort, conv_valid, conv_flag,
    output busy, en_load, en_mul1, en_mul2, en_upd,
           iter_cnt, done, converged, timeout
  );

  modport slave (
    output start, abort, conv_valid, conv_flag,
    input  busy, en_load, en_mul1, en_mul2, en_upd,
           iter_cnt, done, converged, timeout
  );

endinterface

// File: rtl/one_unit_mul_seq.sv
// Iteration sequencer for the one-unit FastICA datapath.
// Walks LOAD -> (MUL1 -> MUL2 -> UPD -> CHK)* -> DONE, holding each stage
// enable for its latency, counting completed iterations, and ending the run
// on a convergence flag or on the iteration limit. abort returns to IDLE
// from any state without a done pulse.
//   clk      : clock, all state on posedge
//   rst      : synchronous active-high reset, overrides everything
//   bus      : control bundle (master side), see one_unit_mul_seq_if
// Every output is a flop; nothing on the bus has a combinational path from
// an input.
module one_unit_mul_seq
  import one_unit_pkg::*;
#(
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int MUL_LAT  = 1,
  parameter int UPD_LAT  = 2,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  one_unit_mul_seq_if.master  bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ITER_W-1:0] iter_q;
  logic              busy_q;
  logic              en_load_q;
  logic              en_mul1_q;
  logic              en_mul2_q;
  logic              en_upd_q;
  logic              done_q;
  logic              conv_q;
  logic              tout_q;

  logic mul_last;
  logic upd_last;
  logic iter_at_max;
  logic iter_full;

  assign mul_last    = lat_last(32'(cnt_q), MUL_LAT);
  assign upd_last    = lat_last(32'(cnt_q), UPD_LAT);
  assign iter_at_max = (iter_q == ITER_W'(MAX_ITER));
  assign iter_full   = &iter_q;

  // State, counters and all outputs advance together so each enable is high
  // exactly while the matching state is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      en_load_q <= 1'b0;
      en_mul1_q <= 1'b0;
      en_mul2_q <= 1'b0;
      en_upd_q  <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        // Cancel: enables drop now, iter_cnt and the sticky flags are kept.
        state_q   <= IDLE;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        en_load_q <= 1'b0;
        en_mul1_q <= 1'b0;
        en_mul2_q <= 1'b0;
        en_upd_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // abort alongside start keeps us idle.
            if (bus.start && !bus.abort) begin
              state_q   <= LOAD;
              busy_q    <= 1'b1;
              en_load_q <= 1'b1;
              iter_q    <= '0;
              conv_q    <= 1'b0;
              tout_q    <= 1'b0;
            end
          end
          LOAD: begin
            state_q   <= MUL1;
            en_load_q <= 1'b0;
            en_mul1_q <= 1'b1;
            cnt_q     <= '0;
          end
          MUL1: begin
            if (mul_last) begin
              state_q   <= MUL2;
              en_mul1_q <= 1'b0;
              en_mul2_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          MUL2: begin
            if (mul_last) begin
              state_q   <= UPD;
              en_mul2_q <= 1'b0;
              en_upd_q  <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          UPD: begin
            if (upd_last) begin
              state_q  <= CHK;
              en_upd_q <= 1'b0;
              cnt_q    <= '0;
              // Saturate rather than wrap.
              if (!iter_full) iter_q <= iter_q + ITER_W'(1);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          CHK: begin
            // Convergence outranks the iteration limit.
            if (bus.conv_valid) begin
              if (bus.conv_flag) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                conv_q  <= 1'b1;
              end else if (iter_at_max) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                tout_q  <= 1'b1;
              end else begin
                // Next iteration re-enters MUL1; LOAD is not repeated.
                state_q   <= MUL1;
                en_mul1_q <= 1'b1;
                cnt_q     <= '0;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            en_load_q <= 1'b0;
            en_mul1_q <= 1'b0;
            en_mul2_q <= 1'b0;
            en_upd_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.en_load   = en_load_q;
  assign bus.en_mul1   = en_mul1_q;
  assign bus.en_mul2   = en_mul2_q;
  assign bus.en_upd    = en_upd_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.done      = done_q;
  assign bus.converged = conv_q;
  assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_one_unit_mul_seq.sv
module tb_one_unit_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // b0: default limit (16); b3: MAX_ITER=3; b1: MAX_ITER=1
  one_unit_mul_seq_if #(.ITER_W(8)) b0 ();
  one_unit_mul_seq_if #(.ITER_W(8)) b3 ();
  one_unit_mul_seq_if #(.ITER_W(8)) b1 ();

  one_unit_mul_seq #(.MAX_ITER(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
  one_unit_mul_seq #(.MAX_ITER(3))  d3 (.clk(clk), .rst(rst), .bus(b3));
  one_unit_mul_seq #(.MAX_ITER(1))  d1 (.clk(clk), .rst(rst), .bus(b1));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {en_load, en_mul1, en_mul2, en_upd}
  logic [3:0] en0, en3, en1;
  assign en0 = {b0.en_load, b0.en_mul1, b0.en_mul2, b0.en_upd};
  assign en3 = {b3.en_load, b3.en_mul1, b3.en_mul2, b3.en_upd};
  assign en1 = {b1.en_load, b1.en_mul1, b1.en_mul2, b1.en_upd};

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot_d0", 32'($onehot0(en0)), 32'd1);
      chk("onehot_d3", 32'($onehot0(en3)), 32'd1);
      chk("onehot_d1", 32'($onehot0(en1)), 32'd1);
    end
  end

  // Walk d0 from cycle 0 (start) through to CHK at cycle 6, checking enables.
  task automatic run_to_chk0(input string tag, input logic [7:0] iter_exp);
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    chk({tag, "_load"}, 32'(en0), 32'b1000);
    chk({tag, "_busy"}, 32'(b0.busy), 32'd1);
    chk({tag, "_flags_clr"}, 32'({b0.converged, b0.timeout}), 32'd0);
    tick(); chk({tag, "_mul1"}, 32'(en0), 32'b0100);
    tick(); chk({tag, "_mul2"}, 32'(en0), 32'b0010);
    tick(); chk({tag, "_upd_a"}, 32'(en0), 32'b0001);
    tick(); chk({tag, "_upd_b"}, 32'(en0), 32'b0001);
    tick(); chk({tag, "_chk_en"}, 32'(en0), 32'b0000);
    chk({tag, "_chk_iter"}, 32'(b0.iter_cnt), 32'(iter_exp));
  endtask

  initial begin
    int done_cyc3, done_cyc1, mul1_cnt3;
    {b0.start, b0.abort, b0.conv_valid, b0.conv_flag} = '0;
    {b3.start, b3.abort, b3.conv_valid, b3.conv_flag} = '0;
    {b1.start, b1.abort, b1.conv_valid, b1.conv_flag} = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_iter", 32'(b0.iter_cnt), 32'd0);
    chk("rst_flags", 32'({b0.done, b0.converged, b0.timeout}), 32'd0);

    // 1 Nominal: converge on the first check
    run_to_chk0("nom", 8'd1);
    b0.conv_valid = 1'b1; b0.conv_flag = 1'b1;
    tick();
    b0.conv_valid = 1'b0; b0.conv_flag = 1'b0;
    chk("nom_done", 32'(b0.done), 32'd1);
    chk("nom_conv", 32'(b0.converged), 32'd1);
    chk("nom_tout", 32'(b0.timeout), 32'd0);
    chk("nom_iter", 32'(b0.iter_cnt), 32'd1);
    chk("nom_busy7", 32'(b0.busy), 32'd1);
    tick();
    chk("nom_busy8", 32'(b0.busy), 32'd0);
    chk("nom_done8", 32'(b0.done), 32'd0);
    chk("nom_conv_sticky", 32'(b0.converged), 32'd1);

    // 4 Abort in MUL2 of iteration 2
    run_to_chk0("abt", 8'd1);
    b0.conv_valid = 1'b1; b0.conv_flag = 1'b0;
    tick();
    b0.conv_valid = 1'b0;
    chk("abt_mul1_it2", 32'(en0), 32'b0100);
    tick();
    chk("abt_mul2_it2", 32'(en0), 32'b0010);
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    chk("abt_busy", 32'(b0.busy), 32'd0);
    chk("abt_en", 32'(en0), 32'd0);
    chk("abt_done", 32'(b0.done), 32'd0);
    chk("abt_iter", 32'(b0.iter_cnt), 32'd1);
    chk("abt_flags", 32'({b0.converged, b0.timeout}), 32'd0);
    tick();
    chk("abt_no_done", 32'(b0.done), 32'd0);

    // 5 New run after abort, with a 20-cycle stall in CHK
    run_to_chk0("stl", 8'd0 + 8'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stl_hold_en", 32'(en0), 32'd0);
      chk("stl_hold_busy", 32'(b0.busy), 32'd1);
    end
    chk("stl_hold_done", 32'(b0.done), 32'd0);
    b0.conv_valid = 1'b1; b0.conv_flag = 1'b0;
    tick();
    b0.conv_valid = 1'b0;
    chk("stl_resume_mul1", 32'(en0), 32'b0100);
    tick(); chk("stl_mul2", 32'(en0), 32'b0010);
    tick(); chk("stl_upd_a", 32'(en0), 32'b0001);
    tick(); chk("stl_upd_b", 32'(en0), 32'b0001);
    tick(); chk("stl_chk2", 32'(en0), 32'd0);
    chk("stl_iter2", 32'(b0.iter_cnt), 32'd2);
    b0.conv_valid = 1'b1; b0.conv_flag = 1'b1;
    tick();
    b0.conv_valid = 1'b0; b0.conv_flag = 1'b0;
    chk("stl_done", 32'(b0.done), 32'd1);
    chk("stl_conv", 32'({b0.converged, b0.timeout}), 32'b10);
    tick();

    // 6 start while busy and conv_valid outside CHK ignored; rst mid-UPD
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    chk("ign_load", 32'(en0), 32'b1000);
    tick();
    b0.start = 1'b1; b0.conv_valid = 1'b1; b0.conv_flag = 1'b1;
    tick();
    b0.start = 1'b0; b0.conv_valid = 1'b0; b0.conv_flag = 1'b0;
    chk("ign_mul2", 32'(en0), 32'b0010);
    chk("ign_done", 32'(b0.done), 32'd0);
    tick();
    chk("ign_upd", 32'(en0), 32'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstm_en", 32'(en0), 32'd0);
    chk("rstm_all", 32'({b0.busy, b0.done, b0.converged, b0.timeout}), 32'd0);
    chk("rstm_iter", 32'(b0.iter_cnt), 32'd0);
    b0.start = 1'b1; b0.abort = 1'b1;
    tick();
    b0.start = 1'b0; b0.abort = 1'b0;
    chk("sa_idle", 32'(b0.busy), 32'd0);
    chk("sa_en", 32'(en0), 32'd0);

    // 2/3 Timeout (MAX_ITER=3) and priority (MAX_ITER=1) in parallel.
    // conv_valid held high throughout, so it must be ignored outside CHK.
    done_cyc3 = -1; done_cyc1 = -1; mul1_cnt3 = 0;
    b3.start = 1'b1; b1.start = 1'b1;
    b3.conv_valid = 1'b1; b3.conv_flag = 1'b0;
    b1.conv_valid = 1'b1; b1.conv_flag = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      b3.start = 1'b0; b1.start = 1'b0;
      if (b3.en_mul1) mul1_cnt3++;
      if (b3.done) begin
        done_cyc3 = c;
        chk("to_tout", 32'(b3.timeout), 32'd1);
        chk("to_conv", 32'(b3.converged), 32'd0);
        chk("to_iter", 32'(b3.iter_cnt), 32'd3);
      end
      if (b1.done) begin
        done_cyc1 = c;
        chk("pri_conv", 32'(b1.converged), 32'd1);
        chk("pri_tout", 32'(b1.timeout), 32'd0);
        chk("pri_iter", 32'(b1.iter_cnt), 32'd1);
      end
    end
    b3.conv_valid = 1'b0; b1.conv_valid = 1'b0; b1.conv_flag = 1'b0;
    chk("to_done_cyc", 32'(done_cyc3), 32'd17);
    chk("pri_done_cyc", 32'(done_cyc1), 32'd7);
    chk("to_mul1_passes", 32'(mul1_cnt3), 32'd3);
    chk("to_idle", 32'(b3.busy), 32'd0);
    chk("to_tout_sticky", 32'(b3.timeout), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
